// File: rtl/intel8080_pkg.sv
// Shared types and helpers for the SRAM access sequencer.
package intel8080_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RECOVER
  } state_t;

  // Active-low strobes are released by driving all ones; slice to width at use.
  localparam logic [31:0] STROBE_OFF = '1;

  function automatic int lane_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 0;
  endfunction

endpackage

// File: rtl/sram_bus_controller_if.sv
// CPU-side request/done handshake between the control FSM and the SRAM sequencer.
interface sram_bus_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  req;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  done;

  modport master (
    output req, write, address, wdata,
    input  rdata, ready, done
  );

  modport slave (
    input  req, write, address, wdata,
    output rdata, ready, done
  );
endinterface

// File: rtl/sram_lane_steer.sv
// Lane steering: replicates CPU write data across all SRAM lanes, decodes the
// active-low lane strobes and extracts the addressed lane from a read word.
module sram_lane_steer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2,
  parameter int LSEL_W     = 1
) (
  input  logic [LSEL_W-1:0]           sel_lane,
  input  logic [LSEL_W-1:0]           cap_lane,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [DATA_WIDTH*LANES-1:0] bus,
  output logic [DATA_WIDTH*LANES-1:0] wdata_rep,
  output logic [LANES-1:0]            lane_n,
  output logic [DATA_WIDTH-1:0]       rd_lane
);

  always_comb begin
    wdata_rep = {LANES{wdata}};
    rd_lane   = bus[int'(cap_lane)*DATA_WIDTH +: DATA_WIDTH];
    lane_n    = '1;
    for (int i = 0; i < LANES; i++) begin
      lane_n[i] = (int'(sel_lane) != i);
    end
  end

endmodule

// File: rtl/sram_bus_controller.sv
// SRAM access sequencer: converts a CPU request/done handshake into timed
// chip/write/output/lane strobes for an asynchronous SRAM with wait states.
module sram_bus_controller
  import intel8080_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SRAM_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 2,
  parameter int TURNAROUND  = 1,
  localparam int LANES      = SRAM_WIDTH / DATA_WIDTH,
  localparam int LANE_BITS  = lane_bits(LANES),
  localparam int LSEL_W     = (LANE_BITS > 0) ? LANE_BITS : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  sram_bus_controller_if.slave            cpu,
  output logic [ADDR_WIDTH-LANE_BITS-1:0] sram_address,
  output logic                            sram_chip_enablen,
  output logic                            sram_write_enablen,
  output logic                            sram_output_enablen,
  output logic [LANES-1:0]                sram_lane_enablen,
  inout  wire  [SRAM_WIDTH-1:0]           sram_data
);

  localparam int CNT_W = 4;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            ready_q, ready_d;
  logic                            done_q, done_d;
  logic                            drive_q, drive_d;
  logic [DATA_WIDTH-1:0]           rdata_q, rdata_d;
  logic [ADDR_WIDTH-LANE_BITS-1:0] addr_d;
  logic                            cen_d, wen_d, oen_d;
  logic [LANES-1:0]                lane_d;
  logic                            accept, finish;

  logic                            write_q;
  logic [LSEL_W-1:0]               lane_q, req_lane;
  logic [SRAM_WIDTH-1:0]           wdata_q, wdata_rep;
  logic [LANES-1:0]                req_strobe_n;
  logic [DATA_WIDTH-1:0]           rd_lane;

  if (LANE_BITS > 0) begin : g_lane
    assign req_lane = cpu.address[LSEL_W-1:0];
  end else begin : g_nolane
    assign req_lane = '0;
  end

  sram_lane_steer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .LSEL_W     (LSEL_W)
  ) u_steer (
    .sel_lane  (req_lane),
    .cap_lane  (lane_q),
    .wdata     (cpu.wdata),
    .bus       (sram_data),
    .wdata_rep (wdata_rep),
    .lane_n    (req_strobe_n),
    .rd_lane   (rd_lane)
  );

  // Write data stays on the bus from SETUP through RECOVER for hold time.
  assign sram_data = drive_q ? wdata_q : 'z;

  assign cpu.ready = ready_q;
  assign cpu.done  = done_q;
  assign cpu.rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    drive_d = drive_q;
    rdata_d = rdata_q;
    addr_d  = sram_address;
    cen_d   = sram_chip_enablen;
    wen_d   = sram_write_enablen;
    oen_d   = sram_output_enablen;
    lane_d  = sram_lane_enablen;
    accept  = 1'b0;
    finish  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu.req) begin
          accept  = 1'b1;
          state_d = SETUP;
          ready_d = 1'b0;
          addr_d  = cpu.address[ADDR_WIDTH-1:LANE_BITS];
          cen_d   = 1'b0;
          lane_d  = req_strobe_n;
          wen_d   = 1'b1;
          oen_d   = cpu.write;
          drive_d = cpu.write;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_W'(WAIT_STATES);
        wen_d   = ~write_q;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          wen_d = 1'b1;
          if (!write_q) rdata_d = rd_lane;
          if (TURNAROUND == 0) begin
            finish = 1'b1;
          end else begin
            state_d = RECOVER;
            cnt_d   = CNT_W'(TURNAROUND - 1);
            cen_d   = 1'b1;
            oen_d   = 1'b1;
            lane_d  = STROBE_OFF[LANES-1:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RECOVER: begin
        if (cnt_q == '0) finish = 1'b1;
        else             cnt_d  = cnt_q - 1'b1;
      end
    endcase

    if (finish) begin
      state_d = IDLE;
      ready_d = 1'b1;
      done_d  = 1'b1;
      drive_d = 1'b0;
      cen_d   = 1'b1;
      wen_d   = 1'b1;
      oen_d   = 1'b1;
      lane_d  = STROBE_OFF[LANES-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      ready_q             <= 1'b1;
      done_q              <= 1'b0;
      drive_q             <= 1'b0;
      rdata_q             <= '0;
      sram_address        <= '0;
      sram_chip_enablen   <= 1'b1;
      sram_write_enablen  <= 1'b1;
      sram_output_enablen <= 1'b1;
      sram_lane_enablen   <= STROBE_OFF[LANES-1:0];
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      ready_q             <= ready_d;
      done_q              <= done_d;
      drive_q             <= drive_d;
      rdata_q             <= rdata_d;
      sram_address        <= addr_d;
      sram_chip_enablen   <= cen_d;
      sram_write_enablen  <= wen_d;
      sram_output_enablen <= oen_d;
      sram_lane_enablen   <= lane_d;
    end
  end

  // Request attributes captured at accept; no reset needed for data.
  always_ff @(posedge clock) begin
    if (accept) begin
      write_q <= cpu.write;
      lane_q  <= req_lane;
      wdata_q <= wdata_rep;
    end
  end

endmodule

// File: tb/tb_sram_bus_controller.sv
// Randomized bench for two controller configurations (16-bit and 8-bit SRAM)
// checked against a byte-addressed memory model and access-timing rules.
module tb_sram_bus_controller;

  localparam int WS_A  = 2;
  localparam int TA_A  = 1;
  localparam int WS_B  = 0;
  localparam int TA_B  = 0;
  localparam int LAT_A = 1 + (WS_A + 1) + TA_A;
  localparam int LAT_B = 1 + (WS_B + 1) + TA_B;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sram_bus_controller_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) ifa ();
  sram_bus_controller_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) ifb ();

  logic [14:0] a_addr;
  logic        a_cen, a_wen, a_oen;
  logic [1:0]  a_lane;
  wire  [15:0] sram_data_a;
  logic [15:0] b_addr;
  logic        b_cen, b_wen, b_oen;
  logic [0:0]  b_lane;
  wire  [7:0]  sram_data_b;

  sram_bus_controller #(
    .DATA_WIDTH(8), .SRAM_WIDTH(16), .ADDR_WIDTH(16),
    .WAIT_STATES(WS_A), .TURNAROUND(TA_A)
  ) dut_a (
    .clock(clock), .reset(reset), .cpu(ifa),
    .sram_address(a_addr), .sram_chip_enablen(a_cen),
    .sram_write_enablen(a_wen), .sram_output_enablen(a_oen),
    .sram_lane_enablen(a_lane), .sram_data(sram_data_a)
  );

  sram_bus_controller #(
    .DATA_WIDTH(8), .SRAM_WIDTH(8), .ADDR_WIDTH(16),
    .WAIT_STATES(WS_B), .TURNAROUND(TA_B)
  ) dut_b (
    .clock(clock), .reset(reset), .cpu(ifb),
    .sram_address(b_addr), .sram_chip_enablen(b_cen),
    .sram_write_enablen(b_wen), .sram_output_enablen(b_oen),
    .sram_lane_enablen(b_lane), .sram_data(sram_data_b)
  );

  // Asynchronous SRAM models with a preload port used during reset.
  logic        pre_we;
  logic [15:0] pre_wa, pre_da;
  logic [15:0] mem_a [32768];
  logic [7:0]  mem_b [65536];

  assign sram_data_a = (!a_cen && !a_oen) ? mem_a[a_addr] : 'z;
  assign sram_data_b = (!b_cen && !b_oen) ? mem_b[b_addr] : 'z;

  always @(posedge clock) begin
    if (pre_we) begin
      mem_a[pre_wa[14:0]] <= pre_da;
      mem_b[pre_wa]       <= pre_da[7:0];
    end else begin
      if (!a_cen && !a_wen)
        for (int i = 0; i < 2; i++)
          if (!a_lane[i]) mem_a[a_addr][i*8 +: 8] <= sram_data_a[i*8 +: 8];
      if (!b_cen && !b_wen && !b_lane[0]) mem_b[b_addr] <= sram_data_b;
    end
  end

  // Observation views so one access task serves both configurations.
  logic [1:0]  obs_ready, obs_done, obs_cen, obs_wen, obs_oen;
  logic [1:0]  obs_lane  [2];
  logic [15:0] obs_addr  [2];
  logic [15:0] obs_bus   [2];
  logic [7:0]  obs_rdata [2];

  assign obs_ready    = {ifb.ready, ifa.ready};
  assign obs_done     = {ifb.done, ifa.done};
  assign obs_cen      = {b_cen, a_cen};
  assign obs_wen      = {b_wen, a_wen};
  assign obs_oen      = {b_oen, a_oen};
  assign obs_lane[0]  = a_lane;
  assign obs_lane[1]  = {1'b1, b_lane};
  assign obs_addr[0]  = {1'b0, a_addr};
  assign obs_addr[1]  = b_addr;
  assign obs_bus[0]   = sram_data_a;
  assign obs_bus[1]   = {8'h00, sram_data_b};
  assign obs_rdata[0] = ifa.rdata;
  assign obs_rdata[1] = ifb.rdata;

  // Reference model: byte-addressed CPU view of each SRAM.
  logic [7:0] ref_mem [2][65536];
  logic [7:0] last_rd [2];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rq, input logic wr,
                       input logic [15:0] ad, input logic [7:0] wd);
    if (sel == 0) begin
      ifa.req = rq; ifa.write = wr; ifa.address = ad; ifa.wdata = wd;
    end else begin
      ifb.req = rq; ifb.write = wr; ifb.address = ad; ifb.wdata = wd;
    end
  endtask

  function automatic logic [31:0] idle_vec(input int sel);
    return {1'b0, obs_ready[sel], obs_done[sel], obs_cen[sel], obs_wen[sel],
            obs_oen[sel], obs_lane[sel], obs_rdata[sel], obs_addr[sel]};
  endfunction

  localparam logic [31:0] IDLE_EXP = {1'b0, 5'b10111, 2'b11, 8'h00, 16'h0000};

  task automatic access(input int sel, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wd);
    int n, lat, we_lo, oe_lo, ce_lo, bad_lane, bad_addr, bad_data, ws, lat_exp;
    logic [1:0]  lane_exp;
    logic [15:0] addr_exp, bus_exp;
    ws       = (sel != 0) ? WS_B : WS_A;
    lat_exp  = (sel != 0) ? LAT_B : LAT_A;
    lane_exp = (sel != 0) ? 2'b10 : (addr[0] ? 2'b01 : 2'b10);
    addr_exp = (sel != 0) ? addr : {1'b0, addr[15:1]};
    bus_exp  = (sel != 0) ? {8'h00, wd} : {wd, wd};
    @(negedge clock);
    drive(sel, 1'b1, wr, addr, wd);
    n = 0;
    while (!obs_ready[sel] && n < 20) begin @(negedge clock); n++; end
    check("accept_ready", 32'(obs_ready[sel]), 32'd1);
    @(posedge clock);
    lat = 0; we_lo = 0; oe_lo = 0; ce_lo = 0; bad_lane = 0; bad_addr = 0; bad_data = 0;
    while (lat < 20) begin
      @(negedge clock);
      if (lat == 0) drive(sel, 1'b0, wr, addr, wd);
      if (obs_done[sel]) break;
      if (!obs_wen[sel]) we_lo++;
      if (!obs_oen[sel]) oe_lo++;
      if (!obs_cen[sel]) begin
        ce_lo++;
        if (obs_lane[sel] !== lane_exp) bad_lane++;
        if (obs_addr[sel] !== addr_exp) bad_addr++;
      end
      if (wr && obs_bus[sel] !== bus_exp) bad_data++;
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_exp));
    check("we_low_cycles", 32'(we_lo), wr ? 32'(ws + 1) : 32'd0);
    check("oe_low_cycles", 32'(oe_lo), wr ? 32'd0 : 32'(ws + 2));
    check("ce_low_cycles", 32'(ce_lo), 32'(ws + 2));
    check("lane_strobes_bad", 32'(bad_lane), 32'd0);
    check("sram_address_bad", 32'(bad_addr), 32'd0);
    check("write_bus_bad", 32'(bad_data), 32'd0);
    check("done_enables", 32'({obs_cen[sel], obs_wen[sel], obs_oen[sel], obs_lane[sel]}), 32'h1F);
    if (wr) ref_mem[sel][addr] = wd;
    else    last_rd[sel] = ref_mem[sel][addr];
    check("rdata", 32'(obs_rdata[sel]), 32'(last_rd[sel]));
  endtask

  task automatic back_to_back();
    int acc, dn, rlo;
    int acc_at [2];
    int dn_at [2];
    logic [7:0] wd;
    wd = 8'($urandom);
    acc = 0; dn = 0; rlo = 0;
    acc_at[0] = -1; acc_at[1] = -1; dn_at[0] = -1; dn_at[1] = -1;
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 16'h0040, wd);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clock);
      if (ifa.done) begin if (dn < 2) dn_at[dn] = i; dn++; end
      if (!ifa.ready) rlo++;
      if (ifa.ready && ifa.req) begin if (acc < 2) acc_at[acc] = i; acc++; end
      @(posedge clock);
      #1;
      if (acc == 1)      drive(0, 1'b1, 1'b0, 16'h0041, 8'h00);
      else if (acc >= 2) drive(0, 1'b0, 1'b0, 16'h0041, 8'h00);
    end
    ref_mem[0][16'h0040] = wd;
    last_rd[0] = ref_mem[0][16'h0041];
    check("b2b_accepts", 32'(acc), 32'd2);
    check("b2b_second_accept_at", 32'(acc_at[1]), 32'd6);
    check("b2b_done_pulses", 32'(dn), 32'd2);
    check("b2b_first_done_at", 32'(dn_at[0]), 32'd6);
    check("b2b_second_done_at", 32'(dn_at[1]), 32'd12);
    check("b2b_ready_low", 32'(rlo), 32'd10);
    check("b2b_rdata", 32'(ifa.rdata), 32'(last_rd[0]));
  endtask

  task automatic reset_mid_access();
    int dn;
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 16'h2000, 8'h3C);
    @(negedge clock);
    drive(0, 1'b0, 1'b1, 16'h2000, 8'h3C);
    @(negedge clock);
    @(negedge clock);
    check("pre_reset_we_low", 32'(a_wen), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_enables", 32'({a_cen, a_wen, a_oen, a_lane}), 32'h1F);
    check("rst_ready_done", 32'({ifa.ready, ifa.done}), 32'h2);
    check("rst_rdata", 32'(ifa.rdata), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (ifa.done) dn++;
    end
    check("rst_no_done", 32'(dn), 32'd0);
    check("rst_ready_after", 32'(ifa.ready), 32'd1);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    pre_we = 1'b0;
    pre_wa = '0;
    pre_da = '0;
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;

    for (int w = 0; w < 256; w++) begin
      @(negedge clock);
      pre_we = 1'b1;
      pre_wa = 16'(w);
      pre_da = 16'($urandom);
      ref_mem[0][16'(2 * w)]     = pre_da[7:0];
      ref_mem[0][16'(2 * w + 1)] = pre_da[15:8];
      ref_mem[1][16'(w)]         = pre_da[7:0];
    end
    @(negedge clock);
    pre_wa = 16'h091A;
    pre_da = 16'hBEEF;
    ref_mem[0][16'h1234] = 8'hEF;
    ref_mem[0][16'h1235] = 8'hBE;
    ref_mem[1][16'h091A] = 8'hEF;
    @(negedge clock);
    pre_we = 1'b0;

    check("reset_state_a", idle_vec(0), IDLE_EXP);
    check("reset_state_b", idle_vec(1), IDLE_EXP);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_hold_a", idle_vec(0), IDLE_EXP);
      check("idle_hold_b", idle_vec(1), IDLE_EXP);
    end

    access(0, 1'b0, 16'h1234, 8'h00);
    check("read_lower_lane", 32'(ifa.rdata), 32'h0EF);
    access(0, 1'b0, 16'h1235, 8'h00);
    check("read_upper_lane", 32'(ifa.rdata), 32'h0BE);
    access(0, 1'b1, 16'h1235, 8'hA5);
    access(0, 1'b0, 16'h1235, 8'h00);

    back_to_back();
    reset_mid_access();

    access(1, 1'b1, 16'h0077, 8'h5A);
    access(1, 1'b0, 16'h0077, 8'h00);
    check("narrow_read_5a", 32'(ifb.rdata), 32'h05A);

    for (int i = 0; i < 40; i++)
      access(0, 1'($urandom), 16'($urandom_range(0, 511)), 8'($urandom));
    for (int i = 0; i < 30; i++)
      access(1, 1'($urandom), 16'($urandom_range(0, 255)), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
